// File: rtl/burst_mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : burst_mem_responder_if
//  Description : Request, read-beat and write-beat bus between an initiator
//                and the burst memory responder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface burst_mem_responder_if #(
    parameter int DATA_WIDTH = 32
);
    logic [31:0]           rd_req_addr;
    logic [4:0]            rd_req_len;
    logic                  rd_req_valid;
    logic                  rd_req_ready;
    logic [DATA_WIDTH-1:0] rd_rdata;
    logic                  rd_valid;
    logic                  rd_last;
    logic                  rd_ready;
    logic [31:0]           wr_req_addr;
    logic [4:0]            wr_req_len;
    logic                  wr_req_valid;
    logic                  wr_req_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_valid;
    logic                  wr_ready;
    logic                  wr_last;
    logic                  busy;
    logic                  err;

    modport master (
        output rd_req_addr, rd_req_len, rd_req_valid, rd_ready,
        output wr_req_addr, wr_req_len, wr_req_valid, wr_data, wr_valid, wr_last,
        input  rd_req_ready, rd_rdata, rd_valid, rd_last,
        input  wr_req_ready, wr_ready, busy, err
    );

    modport slave (
        input  rd_req_addr, rd_req_len, rd_req_valid, rd_ready,
        input  wr_req_addr, wr_req_len, wr_req_valid, wr_data, wr_valid, wr_last,
        output rd_req_ready, rd_rdata, rd_valid, rd_last,
        output wr_req_ready, wr_ready, busy, err
    );
endinterface
`default_nettype wire

// File: rtl/burst_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : burst_mem_responder
//  Description : Single-ported word memory serving one read or write burst at
//                a time, with alternating arbitration and a sticky error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module burst_mem_responder #(
    parameter int MEM_AW     = 10,
    parameter int DATA_WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    burst_mem_responder_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2
    } state_t;

    localparam logic [MEM_AW-1:0] c_WORD_ONE = {{(MEM_AW-1){1'b0}}, 1'b1};
    localparam logic [4:0]        c_CNT_ONE  = 5'd1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [MEM_AW-1:0]     r_word;
    logic [MEM_AW-1:0]     w_word_nxt;
    logic [4:0]            r_len;
    logic [4:0]            r_cnt;
    logic                  r_prefer_wr;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [DATA_WIDTH-1:0] r_mem [0:(1<<MEM_AW)-1];

    logic w_idle;
    logic w_rd_acc;
    logic w_wr_acc;
    logic w_rd_hs;
    logic w_wr_hs;
    logic w_at_len;
    logic w_misaligned;
    logic w_last_err;
    logic w_unused_addr;

    // Readies are masked while reset is held so nothing is granted in reset.
    assign w_idle            = (r_state == IDLE) && rst_n;
    assign bus.rd_req_ready  = w_idle && !(bus.wr_req_valid && r_prefer_wr);
    assign bus.wr_req_ready  = w_idle && !(bus.rd_req_valid && !r_prefer_wr);

    assign w_rd_acc     = bus.rd_req_valid && bus.rd_req_ready;
    assign w_wr_acc     = bus.wr_req_valid && bus.wr_req_ready;
    assign w_rd_hs      = (r_state == RD_BURST) && bus.rd_ready;
    assign w_wr_hs      = (r_state == WR_BURST) && bus.wr_valid;
    assign w_at_len     = (r_cnt == r_len);
    assign w_misaligned = (w_rd_acc && (bus.rd_req_addr[1:0] != 2'b00)) ||
                          (w_wr_acc && (bus.wr_req_addr[1:0] != 2'b00));
    assign w_last_err   = w_wr_hs && (bus.wr_last != w_at_len);
    assign w_unused_addr = ^{bus.rd_req_addr[31:MEM_AW+2], bus.wr_req_addr[31:MEM_AW+2]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_word_nxt  = r_word;
        case (r_state)
            IDLE: begin
                if (w_rd_acc) begin
                    w_state_nxt = RD_BURST;
                    w_word_nxt  = bus.rd_req_addr[MEM_AW+1:2];
                end else if (w_wr_acc) begin
                    w_state_nxt = WR_BURST;
                    w_word_nxt  = bus.wr_req_addr[MEM_AW+1:2];
                end
            end
            RD_BURST: begin
                if (w_rd_hs) begin
                    w_word_nxt = r_word + c_WORD_ONE;
                    if (w_at_len) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            WR_BURST: begin
                if (w_wr_hs) begin
                    w_word_nxt = r_word + c_WORD_ONE;
                    if (w_at_len) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word      <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_prefer_wr <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_word <= w_word_nxt;
            if (w_rd_acc) begin
                r_len       <= bus.rd_req_len;
                r_cnt       <= '0;
                r_prefer_wr <= 1'b1;
            end else if (w_wr_acc) begin
                r_len       <= bus.wr_req_len;
                r_cnt       <= '0;
                r_prefer_wr <= 1'b0;
            end else if (w_rd_hs || w_wr_hs) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
            if (w_misaligned || w_last_err) begin
                r_err <= 1'b1;
            end
        end
    end

    // Prefetching the next word index keeps read beats back-to-back and
    // leaves the presented beat untouched while the initiator stalls.
    always_ff @(posedge clk) begin
        if (w_wr_hs) begin
            r_mem[r_word] <= bus.wr_data;
        end
        r_rdata <= r_mem[w_word_nxt];
    end

    assign bus.rd_rdata = r_rdata;
    assign bus.rd_valid = (r_state == RD_BURST);
    assign bus.rd_last  = (r_state == RD_BURST) && w_at_len;
    assign bus.wr_ready = (r_state == WR_BURST);
    assign bus.busy     = (r_state != IDLE);
    assign bus.err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_burst_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_burst_mem_responder
//  Description : Randomised and directed bench with a word-array memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_burst_mem_responder;
    localparam int MEM_AW = 10;
    localparam int DEPTH  = 1 << MEM_AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    burst_mem_responder_if #(.DATA_WIDTH(32)) bus();

    burst_mem_responder #(.MEM_AW(MEM_AW), .DATA_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] model [DEPTH];
    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] got_data [32];
    logic        got_last [32];
    int          hold_errs;
    int          bubble_errs;

    function automatic int widx(input logic [31:0] addr, input int k);
        return int'((longint'(addr) / 4 + longint'(k)) % DEPTH);
    endfunction

    task automatic idle_inputs();
        bus.rd_req_addr = '0; bus.rd_req_len = '0; bus.rd_req_valid = 1'b0; bus.rd_ready = 1'b0;
        bus.wr_req_addr = '0; bus.wr_req_len = '0; bus.wr_req_valid = 1'b0;
        bus.wr_data = '0; bus.wr_valid = 1'b0; bus.wr_last = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called at a negedge with the request already driven; returns at the
    // negedge after the accepting edge.
    task automatic wait_accept(input bit is_wr, output bit ok);
        int t;
        t = 0;
        #1;
        while (!(is_wr ? bus.wr_req_ready : bus.rd_req_ready) && t < 50) begin
            @(negedge clk); #1; t++;
        end
        ok = is_wr ? bus.wr_req_ready : bus.rd_req_ready;
        if (!ok) begin
            n_total++;
            $display("FAIL accept_timeout: ready=0 after %0d cycles, required 1", t);
        end else begin
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic wr_burst(input logic [31:0] addr, input logic [4:0] len, input logic [31:0] data [32],
                            input int lastpos, input bit gaps, output int n_hs);
        bit ok;
        n_hs = 0;
        bus.wr_req_addr = addr; bus.wr_req_len = len; bus.wr_req_valid = 1'b1;
        wait_accept(1'b1, ok);
        bus.wr_req_valid = 1'b0;
        if (ok) begin
            for (int i = 0; i <= int'(len); i++) begin
                if (gaps) begin
                    repeat ($urandom_range(0, 2)) begin bus.wr_valid = 1'b0; @(negedge clk); end
                end
                bus.wr_data = data[i]; bus.wr_valid = 1'b1; bus.wr_last = (i == lastpos);
                #1;
                if (!bus.wr_ready) begin
                    n_total++;
                    $display("FAIL wr_ready_beat%0d: wr_ready=%b, required 1", i, bus.wr_ready);
                    break;
                end
                model[widx(addr, i)] = data[i];
                n_hs++;
                @(posedge clk); @(negedge clk);
            end
        end
        bus.wr_valid = 1'b0; bus.wr_last = 1'b0;
    endtask

    // mode 0: always ready, 1: alternate ready/stall, 2: random ready
    task automatic rd_burst(input logic [31:0] addr, input logic [4:0] len, input int mode, output int n_beats);
        bit          ok;
        bit          prev_stall;
        bit          r;
        logic [31:0] pd;
        logic        pl;
        int          cyc;
        n_beats = 0; hold_errs = 0; bubble_errs = 0;
        prev_stall = 1'b0; pd = '0; pl = 1'b0; cyc = 0;
        bus.rd_req_addr = addr; bus.rd_req_len = len; bus.rd_req_valid = 1'b1;
        wait_accept(1'b0, ok);
        bus.rd_req_valid = 1'b0;
        if (ok) begin
            while (n_beats <= int'(len) && cyc < 300) begin
                if (prev_stall && (bus.rd_rdata !== pd || bus.rd_last !== pl || bus.rd_valid !== 1'b1))
                    hold_errs++;
                if (bus.rd_valid !== 1'b1) bubble_errs++;
                r = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
                bus.rd_ready = r;
                if (bus.rd_valid && r) begin
                    got_data[n_beats] = bus.rd_rdata;
                    got_last[n_beats] = bus.rd_last;
                    n_beats++;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = bus.rd_valid;
                    pd = bus.rd_rdata; pl = bus.rd_last;
                end
                @(posedge clk); @(negedge clk);
                cyc++;
            end
            if (n_beats <= int'(len)) begin
                n_total++;
                $display("FAIL rd_burst_timeout: beats=%0d, required %0d", n_beats, int'(len) + 1);
            end
        end
        bus.rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        bus.rd_req_valid = 1'b1; bus.wr_req_valid = 1'b1;
        repeat (3) @(negedge clk);
        n_total++;
        if ({bus.rd_req_ready, bus.wr_req_ready, bus.rd_valid, bus.rd_last, bus.wr_ready, bus.busy, bus.err} !== 7'b0)
            $display("FAIL reset_outputs: {rrdy,wrdy,rv,rl,wr,busy,err}=%b, required 0000000",
                     {bus.rd_req_ready, bus.wr_req_ready, bus.rd_valid, bus.rd_last, bus.wr_ready, bus.busy, bus.err});
        else n_pass++;
        rst_n = 1'b1;
        #1;
        n_total++;
        if ({bus.rd_req_ready, bus.wr_req_ready} !== 2'b10)
            $display("FAIL reset_first_grant: {rrdy,wrdy}=%b, required 10", {bus.rd_req_ready, bus.wr_req_ready});
        else n_pass++;
        @(posedge clk); @(negedge clk);
        bus.rd_req_valid = 1'b0; bus.wr_req_valid = 1'b0;
        n_total++;
        if ({bus.busy, bus.rd_valid, bus.rd_last} !== 3'b111)
            $display("FAIL reset_first_accept: {busy,rv,rl}=%b, required 111", {bus.busy, bus.rd_valid, bus.rd_last});
        else n_pass++;
        bus.rd_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.rd_ready = 1'b0;
    endtask

    task automatic test_write_burst();
        logic [31:0] d [32];
        int n;
        do_reset();
        for (int i = 0; i < 32; i++) d[i] = 32'hA0 + 32'(i);
        wr_burst(32'h100, 5'd7, d, 7, 1'b0, n);
        n_total++;
        if (n !== 8) $display("FAIL wr_handshakes: got %0d, required 8", n); else n_pass++;
        n_total++;
        if ({bus.busy, bus.err} !== 2'b00)
            $display("FAIL wr_end_state: {busy,err}=%b, required 00", {bus.busy, bus.err});
        else n_pass++;
    endtask

    task automatic test_read_stall();
        int n;
        rd_burst(32'h100, 5'd7, 1, n);
        for (int i = 0; i < 8; i++) begin
            n_total++;
            if ({got_data[i], got_last[i]} !== {32'hA0 + 32'(i), (i == 7)})
                $display("FAIL rd_stall_beat%0d: data=%h last=%b, required data=%h last=%b",
                         i, got_data[i], got_last[i], 32'hA0 + 32'(i), (i == 7));
            else n_pass++;
        end
        n_total++;
        if (hold_errs !== 0 || bubble_errs !== 0)
            $display("FAIL rd_stall_hold: hold_errs=%0d bubbles=%0d, required 0 0", hold_errs, bubble_errs);
        else n_pass++;
    endtask

    task automatic test_arbitration();
        int n;
        do_reset();
        bus.rd_req_addr = 32'h100; bus.rd_req_len = 5'd0;
        bus.wr_req_addr = 32'h500; bus.wr_req_len = 5'd0;
        bus.rd_req_valid = 1'b1; bus.wr_req_valid = 1'b1;
        #1;
        n_total++;
        if ({bus.rd_req_ready, bus.wr_req_ready} !== 2'b10)
            $display("FAIL arb_first: {rrdy,wrdy}=%b, required 10", {bus.rd_req_ready, bus.wr_req_ready});
        else n_pass++;
        @(posedge clk); @(negedge clk);
        bus.rd_req_valid = 1'b0; bus.rd_ready = 1'b1;
        #1;
        n_total++;
        if ({bus.rd_valid, bus.wr_req_ready} !== 2'b10 || bus.rd_rdata !== model[widx(32'h100, 0)])
            $display("FAIL arb_read_beat: rv=%b wrdy=%b data=%h, required rv=1 wrdy=0 data=%h",
                     bus.rd_valid, bus.wr_req_ready, bus.rd_rdata, model[widx(32'h100, 0)]);
        else n_pass++;
        @(posedge clk); @(negedge clk);
        bus.rd_ready = 1'b0; bus.rd_req_valid = 1'b1;
        #1;
        n_total++;
        if ({bus.rd_req_ready, bus.wr_req_ready} !== 2'b01)
            $display("FAIL arb_second: {rrdy,wrdy}=%b, required 01", {bus.rd_req_ready, bus.wr_req_ready});
        else n_pass++;
        @(posedge clk); @(negedge clk);
        bus.rd_req_valid = 1'b0; bus.wr_req_valid = 1'b0;
        bus.wr_data = 32'h5A5A_0001; bus.wr_valid = 1'b1; bus.wr_last = 1'b1;
        #1;
        n_total++;
        if (bus.wr_ready !== 1'b1) $display("FAIL arb_write_beat: wr_ready=%b, required 1", bus.wr_ready);
        else n_pass++;
        model[widx(32'h500, 0)] = 32'h5A5A_0001;
        @(posedge clk); @(negedge clk);
        bus.wr_valid = 1'b0; bus.wr_last = 1'b0;
        n_total++;
        if ({bus.busy, bus.err} !== 2'b00)
            $display("FAIL arb_end_state: {busy,err}=%b, required 00", {bus.busy, bus.err});
        else n_pass++;
        rd_burst(32'h500, 5'd0, 0, n);
        n_total++;
        if (got_data[0] !== 32'h5A5A_0001) $display("FAIL arb_readback: got %h, required 5a5a0001", got_data[0]);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [31:0] d [32];
        int n;
        do_reset();
        for (int i = 0; i < 32; i++) d[i] = $urandom;
        wr_burst(32'hFF8, 5'd3, d, 3, 1'b0, n);
        rd_burst(32'hFFC, 5'd0, 0, n);
        n_total++;
        if (got_data[0] !== d[1]) $display("FAIL wrap_word1023: got %h, required %h", got_data[0], d[1]); else n_pass++;
        rd_burst(32'h0, 5'd1, 0, n);
        n_total++;
        if (got_data[0] !== d[2] || got_data[1] !== d[3])
            $display("FAIL wrap_word0_1: got %h %h, required %h %h", got_data[0], got_data[1], d[2], d[3]);
        else n_pass++;
        rd_burst(32'hFF8, 5'd3, 2, n);
        n_total++;
        if ({got_data[0], got_data[1], got_data[2], got_data[3]} !== {d[0], d[1], d[2], d[3]})
            $display("FAIL wrap_readback: got %h %h %h %h, required %h %h %h %h",
                     got_data[0], got_data[1], got_data[2], got_data[3], d[0], d[1], d[2], d[3]);
        else n_pass++;
    endtask

    task automatic test_err();
        logic [31:0] d [32];
        int n;
        int mism;
        do_reset();
        for (int i = 0; i < 32; i++) d[i] = $urandom;
        wr_burst(32'h200, 5'd7, d, 5, 1'b0, n);
        n_total++;
        if (n !== 8 || bus.err !== 1'b1 || bus.busy !== 1'b0)
            $display("FAIL err_early_last: hs=%0d err=%b busy=%b, required 8 1 0", n, bus.err, bus.busy);
        else n_pass++;
        rd_burst(32'h200, 5'd7, 0, n);
        mism = 0;
        for (int i = 0; i < 8; i++) if (got_data[i] !== d[i]) mism++;
        n_total++;
        if (mism !== 0 || bus.err !== 1'b1)
            $display("FAIL err_data_intact: mismatches=%0d err=%b, required 0 1", mism, bus.err);
        else n_pass++;
        do_reset();
        n_total++;
        if (bus.err !== 1'b0) $display("FAIL err_cleared: err=%b, required 0", bus.err); else n_pass++;
        wr_burst(32'h102, 5'd0, d, 0, 1'b0, n);
        n_total++;
        if (bus.err !== 1'b1) $display("FAIL err_misaligned: err=%b, required 1", bus.err); else n_pass++;
        rd_burst(32'h100, 5'd0, 0, n);
        n_total++;
        if (got_data[0] !== d[0]) $display("FAIL err_aligned_write: got %h, required %h", got_data[0], d[0]);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        logic [31:0] d [32];
        int n;
        bit ok;
        do_reset();
        for (int i = 0; i < 32; i++) d[i] = $urandom;
        wr_burst(32'h300, 5'd7, d, 7, 1'b0, n);
        bus.rd_req_addr = 32'h300; bus.rd_req_len = 5'd7; bus.rd_req_valid = 1'b1;
        wait_accept(1'b0, ok);
        bus.rd_req_valid = 1'b0;
        bus.rd_ready = 1'b1;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        bus.rd_ready = 1'b0;
        #1;
        n_total++;
        if (bus.rd_valid !== 1'b1 || bus.rd_last !== 1'b0 || bus.rd_rdata !== d[3])
            $display("FAIL midrst_beat3: rv=%b rl=%b data=%h, required 1 0 %h", bus.rd_valid, bus.rd_last, bus.rd_rdata, d[3]);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({bus.rd_valid, bus.busy, bus.rd_req_ready} !== 3'b000)
            $display("FAIL midrst_abort: {rv,busy,rrdy}=%b, required 000", {bus.rd_valid, bus.busy, bus.rd_req_ready});
        else n_pass++;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        bus.wr_req_addr = 32'h400; bus.wr_req_len = 5'd0; bus.wr_req_valid = 1'b1;
        #1;
        n_total++;
        if (bus.wr_req_ready !== 1'b1) $display("FAIL midrst_accept: wrdy=%b, required 1", bus.wr_req_ready);
        else n_pass++;
        d[0] = 32'hC0DE_0400;
        wr_burst(32'h400, 5'd0, d, 0, 1'b0, n);
        rd_burst(32'h300, 5'd7, 0, n);
        n_total++;
        if (got_data[7] !== model[widx(32'h300, 7)] || got_data[3] !== model[widx(32'h300, 3)])
            $display("FAIL midrst_mem_kept: got %h %h, required %h %h", got_data[3], got_data[7],
                     model[widx(32'h300, 3)], model[widx(32'h300, 7)]);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] d [32];
        logic [31:0] base_q [$];
        logic [4:0]  len_q [$];
        logic [31:0] a;
        logic [4:0]  len;
        int n;
        int k;
        int mism;
        do_reset();
        for (int it = 0; it < 30; it++) begin
            if (base_q.size() == 0 || $urandom_range(0, 1) == 0) begin
                a   = {20'($urandom), 10'($urandom), 2'b00};
                len = 5'($urandom);
                for (int i = 0; i < 32; i++) d[i] = $urandom;
                wr_burst(a, len, d, int'(len), 1'b1, n);
                base_q.push_back(a); len_q.push_back(len);
            end else begin
                k   = $urandom_range(0, base_q.size() - 1);
                a   = {20'($urandom), base_q[k][11:0]};
                len = len_q[k];
                rd_burst(a, len, 2, n);
                mism = 0;
                for (int i = 0; i <= int'(len); i++)
                    if (got_data[i] !== model[widx(a, i)] || got_last[i] !== (i == int'(len))) mism++;
                n_total++;
                if (mism !== 0 || hold_errs !== 0 || bubble_errs !== 0)
                    $display("FAIL rand_read_%0d: mismatches=%0d hold=%0d bubbles=%0d, required 0 0 0",
                             it, mism, hold_errs, bubble_errs);
                else n_pass++;
            end
        end
        n_total++;
        if ({bus.err, bus.busy} !== 2'b00)
            $display("FAIL rand_end_state: {err,busy}=%b, required 00", {bus.err, bus.busy});
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = 'x;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_write_burst();
        test_read_stall();
        test_arbitration();
        test_wrap();
        test_err();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/burst_mem_responder.md
BURST_MEM_RESPONDER -- requirements
Module: burst_mem_responder

Interface
REQ-001 SHALL have parameter MEM_AW, default 10, meaning log2 of memory depth in 32-bit words (1024 words, 4 KiB).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the beat width; only 32 is supported.
REQ-003 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rd_req_addr  in  32  read burst byte address.
- rd_req_len  in  5  read beats minus 1.
- rd_req_valid  in  1  read request valid.
- rd_req_ready  out  1  read request accepted.
- rd_rdata  out  32  read beat data.
- rd_valid  out  1  read beat valid.
- rd_last  out  1  final read beat.
- rd_ready  in  1  initiator accepts a read beat.
- wr_req_addr  in  32  write burst byte address.
- wr_req_len  in  5  write beats minus 1.
- wr_req_valid  in  1  write request valid.
- wr_req_ready  out  1  write request accepted.
- wr_data  in  32  write beat data.
- wr_valid  in  1  write beat valid.
- wr_ready  out  1  responder accepts a write beat.
- wr_last  in  1  initiator marks the final write beat.
- busy  out  1  a burst is in progress.
- err  out  1  sticky protocol error flag.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-005 SHALL hold an internal 2^MEM_AW x 32 memory; word index = addr[MEM_AW+1:2]; upper address bits ignored.
REQ-006 SHALL implement FSM states IDLE, RD_BURST, WR_BURST; only one burst is active at a time.
REQ-007 SHALL drive rd_req_ready and wr_req_ready combinationally, and only in IDLE; a request is accepted on valid&&ready.
REQ-008 SHALL arbitrate when both requests are valid in IDLE: grant the type not granted last; after reset, read wins first.
REQ-009 SHALL, on acceptance, latch address and len, clear the beat counter, assert busy from the next cycle, and move to the granted burst state.
REQ-010 SHALL present read beat 0 with rd_valid=1 in the cycle after acceptance; rd_rdata = mem[word index].
REQ-011 SHALL advance a read beat only on rd_valid&&rd_ready; the next beat is valid in the following cycle with no bubble.
REQ-012 SHALL hold rd_rdata, rd_valid and rd_last stable while rd_valid&&!rd_ready.
REQ-013 SHALL assert rd_last exactly on beat index == latched len; handshake of that beat returns FSM to IDLE next cycle.
REQ-014 SHALL assert wr_ready throughout WR_BURST; each wr_valid&&wr_ready writes wr_data to mem[current word] and increments the counter.
REQ-015 SHALL end a write burst on handshake of beat index == latched len regardless of wr_last, then return to IDLE.
REQ-016 SHALL increment the word index by 1 per beat, wrapping modulo 2^MEM_AW.
REQ-017 SHALL set err if wr_last=1 on a write beat with index != len, or wr_last=0 on beat index == len.
REQ-018 SHALL set err if an accepted request has addr[1:0] != 0; the burst still proceeds using aligned addresses.
REQ-019 SHALL keep err set until reset; err does not alter data-path behaviour.
REQ-020 SHALL make a write in the same cycle a read beat is fetched impossible, since bursts are exclusive; there are no read-after-write hazards across bursts.
REQ-021 SHALL deassert busy in the cycle the FSM is back in IDLE.

Reset
REQ-022 SHALL, while rst_n=0, force IDLE, with rd_req_ready=0, wr_req_ready=0, rd_valid=0, rd_last=0, wr_ready=0, busy=0, err=0, counters=0, and arbitration favouring read.
REQ-023 SHALL abort any in-progress burst on reset; memory contents are not cleared; the first request is accepted the first cycle after rst_n rises.

Verification
REQ-024 SHALL cover: write burst addr 0x100, len 7, data 0xA0..0xA7, wr_last on beat 7 -> 8 handshakes, err=0, busy low after burst.
REQ-025 SHALL cover: read addr 0x100, len 7, rd_ready toggled 1/0 -> beats 0xA0..0xA7 in order, rd_last only with 0xA7, data held during stalls.
REQ-026 SHALL cover: rd_req_valid and wr_req_valid both high in IDLE twice -> read granted first, then write.
REQ-027 SHALL cover: write addr 0xFF8 (MEM_AW=10), len 3 -> words 1022, 1023, 0, 1 written; read back matches.
REQ-028 SHALL cover: write len 7 with wr_last on beat 5 -> err=1, burst still consumes 8 beats; misaligned addr 0x102 -> err=1.
REQ-029 SHALL cover: rst_n pulled low mid read burst (beat 3) -> rd_valid=0 immediately, IDLE, new request accepted after release.
